evt_inc: RTL and testbench

Event front-end that turns an asynchronous external event line into clean single-cycle `inc` pulses for the pseudo-random counters (`ctr_pr4/5/7`), which it feeds directly. It synchronizes the input, rejects glitches shorter than a programmable stability window, selects the counted edge polarity and applies an optional event prescaler. A runtime enable and a synchronous clear let the owner gate counting without touching the counter.

---
 rtl/evt_inc_pkg.sv | 20 ++
 rtl/evt_inc_if.sv | 12 +
 rtl/evt_inc_sync_ff.sv | 23 ++
 rtl/evt_inc.sv | 87 ++++++++
 tb/tb_evt_inc.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/evt_inc_pkg.sv
// Shared definitions for the event front-end: counted-edge encodings and
// the helper that decides whether an accepted transition is counted.
package evt_inc_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // new_lvl is the level just accepted, so 1 means a 0->1 transition
    function automatic logic edge_match(input int sel, input logic new_lvl);
        logic hit;
        case (sel)
            EDGE_RISE: hit = new_lvl;
            EDGE_FALL: hit = ~new_lvl;
            default:   hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/evt_inc_if.sv
// Event-side signal bundle: raw event, enable and clear toward the front-end,
// counted pulse and filtered level back out.
interface evt_inc_if;
    logic evt;
    logic en;
    logic clr;
    logic inc;
    logic lvl;

    modport master (output evt, en, clr, input inc, lvl);
    modport slave  (input evt, en, clr, output inc, lvl);
endinterface

// File: rtl/evt_inc_sync_ff.sv
// Reset-to-0 multi-flop synchronizer for a single asynchronous bit.
module evt_inc_sync_ff #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC-1:0] chain_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[SYNC-2:0], d};
        end
    end

    assign q = chain_reg[SYNC-1];

endmodule

// File: rtl/evt_inc.sv
// Event front-end: synchronize, glitch-filter, pick the counted edge and
// prescale into one-cycle inc pulses for the downstream counter.
module evt_inc
    import evt_inc_pkg::*;
#(
    parameter int SYNC = 2,
    parameter int FILT = 4,
    parameter int DIV  = 1,
    parameter int EDGE = EDGE_RISE
) (
    input  logic      clk,
    input  logic      rst_n,
    evt_inc_if.slave  bus
);

    localparam int FW = $clog2(FILT + 1);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILT - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

    logic          s;
    logic          lvl_reg, lvl_next;
    logic [FW-1:0] fcnt_reg, fcnt_next;
    logic [PW-1:0] pcnt_reg, pcnt_next;
    logic          inc_reg, inc_next;
    logic          accept;
    logic          qual;

    evt_inc_sync_ff #(.SYNC(SYNC)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.evt),
        .q     (s)
    );

    // A level is taken only after FILT consecutive cycles of disagreement
    always_comb begin
        lvl_next  = lvl_reg;
        fcnt_next = fcnt_reg;
        accept    = 1'b0;
        if (s == lvl_reg) begin
            fcnt_next = '0;
        end else if (fcnt_reg == FCNT_LAST) begin
            lvl_next  = s;
            fcnt_next = '0;
            accept    = 1'b1;
        end else begin
            fcnt_next = fcnt_reg + 1'b1;
        end
    end

    assign qual = accept && edge_match(EDGE, lvl_next);

    // Clear wins over a coincident edge; disabled edges leave the phase alone
    always_comb begin
        pcnt_next = pcnt_reg;
        inc_next  = 1'b0;
        if (bus.clr) begin
            pcnt_next = '0;
        end else if (qual && bus.en) begin
            if (pcnt_reg == PCNT_LAST) begin
                inc_next  = 1'b1;
                pcnt_next = '0;
            end else begin
                pcnt_next = pcnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_reg  <= 1'b0;
            fcnt_reg <= '0;
            pcnt_reg <= '0;
            inc_reg  <= 1'b0;
        end else begin
            lvl_reg  <= lvl_next;
            fcnt_reg <= fcnt_next;
            pcnt_reg <= pcnt_next;
            inc_reg  <= inc_next;
        end
    end

    assign bus.inc = inc_reg;
    assign bus.lvl = lvl_reg;

endmodule

// File: tb/tb_evt_inc.sv
// Bench for evt_inc: three parameterizations checked every cycle against an
// event-level model, plus directed scenarios with literal pulse counts.
module tb_evt_inc;

    localparam int SYNC_N = 2;
    localparam int FILT_N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic evt_d [3];
    logic en_d  [3];
    logic clr_d [3];
    logic inc_w [3];
    logic lvl_w [3];

    evt_inc_if if0 ();
    evt_inc_if if1 ();
    evt_inc_if if2 ();

    assign if0.evt = evt_d[0];  assign if0.en = en_d[0];  assign if0.clr = clr_d[0];
    assign if1.evt = evt_d[1];  assign if1.en = en_d[1];  assign if1.clr = clr_d[1];
    assign if2.evt = evt_d[2];  assign if2.en = en_d[2];  assign if2.clr = clr_d[2];
    assign inc_w[0] = if0.inc;  assign lvl_w[0] = if0.lvl;
    assign inc_w[1] = if1.inc;  assign lvl_w[1] = if1.lvl;
    assign inc_w[2] = if2.inc;  assign lvl_w[2] = if2.lvl;

    evt_inc #(.SYNC(2), .FILT(4), .DIV(1), .EDGE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    evt_inc #(.SYNC(2), .FILT(4), .DIV(3), .EDGE(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    evt_inc #(.SYNC(2), .FILT(4), .DIV(4), .EDGE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int n_tests = 0;
    int n_fail  = 0;
    int inc_cnt [3];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 4;
    endfunction

    function automatic int edge_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: s is the evt value seen SYNC edges ago; a level is accepted after
    // FILT consecutive disagreeing cycles; counted edges are taken modulo DIV.
    logic [7:0] m_chain [3];
    logic       m_lvl   [3];
    logic       m_inc   [3];
    int         m_run   [3];
    int         m_pcnt  [3];
    logic       m_s, m_acc, m_counted;

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_chain[i] = '0; m_lvl[i] = 1'b0; m_inc[i] = 1'b0;
            m_run[i] = 0; m_pcnt[i] = 0; inc_cnt[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    m_chain[i] = '0; m_lvl[i] = 1'b0; m_inc[i] = 1'b0;
                    m_run[i] = 0; m_pcnt[i] = 0;
                end else begin
                    m_s   = m_chain[i][SYNC_N-1];
                    m_acc = 1'b0;
                    if (m_s == m_lvl[i]) begin
                        m_run[i] = 0;
                    end else if (m_run[i] + 1 >= FILT_N) begin
                        m_lvl[i] = m_s;
                        m_run[i] = 0;
                        m_acc    = 1'b1;
                    end else begin
                        m_run[i] = m_run[i] + 1;
                    end
                    m_counted = m_acc && ((edge_of(i) == 2) ||
                                          (edge_of(i) == 0 && m_lvl[i]) ||
                                          (edge_of(i) == 1 && !m_lvl[i]));
                    m_inc[i] = 1'b0;
                    if (clr_d[i]) begin
                        m_pcnt[i] = 0;
                    end else if (m_counted && en_d[i]) begin
                        m_pcnt[i] = m_pcnt[i] + 1;
                        if (m_pcnt[i] == div_of(i)) begin
                            m_inc[i]  = 1'b1;
                            m_pcnt[i] = 0;
                        end
                    end
                    m_chain[i] = {m_chain[i][6:0], evt_d[i]};
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("lvl%0d_model", i), 32'(lvl_w[i]), 32'(m_lvl[i]));
                check($sformatf("inc%0d_model", i), 32'(inc_w[i]), 32'(m_inc[i]));
                if (inc_w[i] === 1'b1) inc_cnt[i]++;
            end
        end
    end

    task automatic rise2();
        evt_d[2] = 1'b1; tick(8);
        evt_d[2] = 1'b0; tick(8);
    endtask

    int exp_both [6];
    int exp_en   [6];
    logic en_seq [6];

    initial begin
        exp_both = '{0, 0, 1, 1, 1, 2};
        exp_en   = '{0, 0, 0, 0, 0, 1};
        en_seq   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            evt_d[i] = 1'b0; en_d[i] = 1'b1; clr_d[i] = 1'b0;
        end

        // evt high through reset: counted as a rising edge at edge SYNC+FILT
        evt_d[0] = 1'b1;
        tick(3);
        check("reset_lvl", 32'(lvl_w[0]), 32'd0);
        check("reset_inc", 32'(inc_w[0]), 32'd0);
        rst_n = 1'b1;
        $display("[TB] reset released with evt0 high");
        tick(5);
        check("rst_hi_edge5_lvl", 32'(lvl_w[0]), 32'd0);
        tick(1);
        check("rst_hi_edge6_lvl", 32'(lvl_w[0]), 32'd1);
        check("rst_hi_edge6_inc", 32'(inc_w[0]), 32'd1);
        tick(1);
        check("rst_hi_edge7_inc", 32'(inc_w[0]), 32'd0);
        evt_d[0] = 1'b0; tick(10);
        check("fall_lvl", 32'(lvl_w[0]), 32'd0);
        check("fall_no_inc", 32'(inc_cnt[0]), 32'd1);

        $display("[TB] evt0 step 0->1");
        evt_d[0] = 1'b1;
        tick(5);
        check("step_edge5_inc", 32'(inc_w[0]), 32'd0);
        tick(1);
        check("step_edge6_lvl", 32'(lvl_w[0]), 32'd1);
        check("step_edge6_inc", 32'(inc_w[0]), 32'd1);
        evt_d[0] = 1'b0; tick(10);
        check("step_cnt", 32'(inc_cnt[0]), 32'd2);

        $display("[TB] evt0 3-cycle glitch");
        evt_d[0] = 1'b1; tick(3); evt_d[0] = 1'b0; tick(10);
        check("glitch3_lvl", 32'(lvl_w[0]), 32'd0);
        check("glitch3_cnt", 32'(inc_cnt[0]), 32'd2);
        $display("[TB] evt0 4-cycle pulse");
        evt_d[0] = 1'b1; tick(4); evt_d[0] = 1'b0; tick(12);
        check("pulse4_cnt", 32'(inc_cnt[0]), 32'd3);
        check("pulse4_lvl", 32'(lvl_w[0]), 32'd0);

        $display("[TB] reset during a falling filter run");
        evt_d[0] = 1'b1; tick(8);
        check("pre_rst_lvl", 32'(lvl_w[0]), 32'd1);
        check("pre_rst_cnt", 32'(inc_cnt[0]), 32'd4);
        evt_d[0] = 1'b0; tick(4);
        check("midrun_lvl", 32'(lvl_w[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_lvl", 32'(lvl_w[0]), 32'd0);
        check("async_rst_inc", 32'(inc_w[0]), 32'd0);
        evt_d[0] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("restart_edge5_lvl", 32'(lvl_w[0]), 32'd0);
        tick(1);
        check("restart_edge6_inc", 32'(inc_w[0]), 32'd1);
        evt_d[0] = 1'b0; tick(10);

        // DIV=3, both edges: pulses on transitions 3 and 6 only
        for (int k = 0; k < 6; k++) begin
            evt_d[1] = ~evt_d[1];
            tick(8);
            $display("[TB] inst1 transition %0d, inc count %0d", k + 1, inc_cnt[1]);
            check($sformatf("both_div3_t%0d", k + 1), 32'(inc_cnt[1]), 32'(exp_both[k]));
        end

        // DIV=4 rising: en low for the middle two edges keeps the phase
        for (int k = 0; k < 6; k++) begin
            en_d[2] = en_seq[k];
            rise2();
            $display("[TB] inst2 edge %0d en=%0b, inc count %0d", k + 1, en_seq[k], inc_cnt[2]);
            check($sformatf("en_div4_e%0d", k + 1), 32'(inc_cnt[2]), 32'(exp_en[k]));
        end
        en_d[2] = 1'b1;

        $display("[TB] inst2 clr after two edges");
        rise2(); rise2();
        clr_d[2] = 1'b1; tick(1); clr_d[2] = 1'b0;
        rise2(); rise2();
        check("clr_div4_cnt", 32'(inc_cnt[2]), 32'd1);

        $display("[TB] inst2 clr coincident with terminal edge");
        rise2();
        evt_d[2] = 1'b1;
        tick(5);
        clr_d[2] = 1'b1;
        tick(1);
        clr_d[2] = 1'b0;
        check("clr_coinc_inc", 32'(inc_w[2]), 32'd0);
        evt_d[2] = 1'b0; tick(8);
        check("clr_coinc_cnt", 32'(inc_cnt[2]), 32'd1);
        rise2(); rise2(); rise2();
        check("after_clr_3edges", 32'(inc_cnt[2]), 32'd1);
        rise2();
        check("after_clr_4edges", 32'(inc_cnt[2]), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
